sbd_sqrt_fp_ctrl: RTL and testbench
===================================

Name: sbd_sqrt_fp_ctrl

Overview:
Operand-issue and result-pack stage wrapped around the sbd_sqrt_fp32 core and its sequencing state machine. Accepts an IEEE-754 single over valid/ready and classifies it. Special cases bypass the core. Normal operands are aligned into a radicand, and the core's VAL_IN is held until VAL_OUT. The returned root is RNE-rounded, packed and presented downstream over valid/ready.

Parameters:
MW, 52, radicand width driven to core
RW, 26, root width returned by core (24 significand + guard + round)
QNAN, 32'h7FC00000, canonical quiet NaN result

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
IN_VALID  input  1  operand valid
IN_READY  output  1  operand accepted when IN_VALID & IN_READY
IN_DATA  input  32  IEEE-754 single operand
OUT_VALID  output  1  result valid
OUT_READY  input  1  downstream accepts result
OUT_DATA  output  32  IEEE-754 single result
OUT_INVALID  output  1  invalid-operation flag, qualified by OUT_VALID
CORE_VAL  output  1  to core VAL_IN
CORE_RAD  output  MW  aligned radicand to core
CORE_VAL_OUT  input  1  core VAL_OUT, single-cycle done pulse
CORE_ROOT  input  RW  integer root, valid when CORE_VAL_OUT=1
CORE_REM_NZ  input  1  remainder nonzero (sticky), valid with CORE_VAL_OUT
BUSY  output  1  state != IDLE

Behaviour:
- Reset (async, RST_N=0): state=IDLE. IN_READY=0 while in reset, 1 after release. OUT_VALID=0, OUT_DATA=0, OUT_INVALID=0, CORE_VAL=0, CORE_RAD=0, BUSY=0.
- All outputs are registered except IN_READY and BUSY, which decode state. IN_READY=1 only in IDLE.
- States and transitions:
  - IDLE: on IN_VALID, capture IN_DATA and classify. Special -> BYPASS. Normal -> ISSUE. No accept while IN_VALID=0.
  - BYPASS: load OUT_DATA and OUT_INVALID, set OUT_VALID -> DONE.
  - ISSUE: CORE_VAL=1 and CORE_RAD stable. On the edge sampling CORE_VAL_OUT=1: clear CORE_VAL, latch CORE_ROOT and CORE_REM_NZ -> PACK. CORE_VAL must be 0 the cycle after VAL_OUT, otherwise the core restarts.
  - PACK: round and pack into OUT_DATA, set OUT_VALID -> DONE.
  - DONE: hold OUT_VALID, OUT_DATA and OUT_INVALID stable until OUT_READY=1, then clear OUT_VALID -> IDLE. No new accept in the same cycle.
- Classification (E = exponent field, F = fraction field, s = sign):
  - E=0: zero or denormal, flushed to signed zero. Result {s,31'b0}, INVALID=0.
  - E=255 and F!=0: NaN. Result QNAN, INVALID=1 if signalling (F[22]=0), else 0.
  - +inf: result +inf, INVALID=0.
  - s=1, nonzero (incl. -inf): result QNAN, INVALID=1.
  - Otherwise normal.
- Alignment: m = {1,F} (24b), e = E-127.
  - e odd: CORE_RAD = {m,28'b0}.
  - e even: CORE_RAD = {1'b0,m,27'b0}.
  - Root lies in [2^25, 2^26).
- Exponent: result biased exponent = (e>>>1)+127, using arithmetic shift. Always in 64..190, so no overflow or underflow.
- Rounding (RNE): LSB=root[2], G=root[1], S=root[0]|REM_NZ. Increment root[25:2] if G&(S|LSB). A carry out to 2^24 renormalizes: fraction=0, exponent+1. Result sign is always 0.
- Latency:
  - Bypass: accept edge +2 cycles to OUT_VALID.
  - Normal: core latency +2 cycles (ISSUE entry to CORE_VAL_OUT, +PACK, +DONE).
- CORE_VAL_OUT outside ISSUE is ignored.
- Reset mid-operation returns to IDLE immediately. The core's own val register may still be active; the next ISSUE is allowed only after a core VAL_OUT pulse or a core reset (system integration ties both resets).

Test Plan:
- IN_DATA=32'h40800000 (4.0) -> OUT_DATA=32'h40000000, OUT_INVALID=0, CORE_RAD bit 50 set (even e).
- IN_DATA=32'h40000000 (2.0) -> OUT_DATA=32'h3FB504F3; CORE_VAL high from ISSUE entry until the edge after CORE_VAL_OUT, and low the following cycle.
- IN_DATA=32'hBF800000 (-1.0) -> OUT_DATA=32'h7FC00000, OUT_INVALID=1, OUT_VALID 2 cycles after accept, CORE_VAL never asserted.
- IN_DATA=32'h80000000, 32'h00000001, 32'h7F800000, 32'h7FA00000 -> 32'h80000000, 32'h00000000, 32'h7F800000, 32'h7FC00000 (INVALID=1 for the last only).
- Result with OUT_READY=0 for 10 cycles -> OUT_VALID and OUT_DATA stable, IN_READY=0; OUT_READY=1 -> one transfer, IN_READY=1 the next cycle.
- RST_N pulsed low during ISSUE -> CORE_VAL, OUT_VALID and BUSY=0 asynchronously. After release plus one core completion, 32'h41100000 (9.0) -> 32'h40400000.

Source files
------------

// File: rtl/sbd_sqrt_fp_ctrl.sv
// ---------------------------------------------------------------------------
// sbd_sqrt_fp_ctrl
//
// Issue/pack stage around the sbd_sqrt_fp32 integer square-root core.
// It accepts one IEEE-754 single operand at a time and classifies it.
// Special operands (zero/denormal, NaN, +inf, negative) are answered
// directly. Normal operands are aligned into a radicand and handed to the
// core. The integer root that comes back is rounded to nearest-even, packed
// into a single and returned.
//
// Handshake: a transfer happens on a rising CLK edge where VALID and READY
// are both 1. The producer holds VALID and DATA steady until that edge.
// READY may be low while VALID waits. Both channels follow this rule.
//
// Ports:
//   CLK, RST_N       clock (rising edge), asynchronous active-low reset
//   IN_VALID/READY   operand channel; IN_DATA is the operand
//   OUT_VALID/READY  result channel; OUT_DATA is the result, OUT_INVALID
//                    is the invalid-operation flag
//   CORE_VAL         core VAL_IN; held from ISSUE entry until VAL_OUT
//   CORE_RAD         aligned radicand (MW bits)
//   CORE_VAL_OUT     core done pulse; CORE_ROOT/CORE_REM_NZ valid with it
//   BUSY             controller is not idle
//   DBG_STATE        current FSM state encoding
// ---------------------------------------------------------------------------
module sbd_sqrt_fp_ctrl #(
    parameter int          MW   = 52,
    parameter int          RW   = 26,
    parameter logic [31:0] QNAN = 32'h7FC00000
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [31:0]   IN_DATA,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [31:0]   OUT_DATA,
    output logic          OUT_INVALID,
    output logic          CORE_VAL,
    output logic [MW-1:0] CORE_RAD,
    input  logic          CORE_VAL_OUT,
    input  logic [RW-1:0] CORE_ROOT,
    input  logic          CORE_REM_NZ,
    output logic          BUSY,
    output logic [2:0]    DBG_STATE
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BYPASS = 3'd1,
        S_ISSUE  = 3'd2,
        S_PACK   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t r_state, w_next;

    logic          r_out_valid, r_out_invalid, r_core_val;
    logic [31:0]   r_out_data;
    logic [MW-1:0] r_core_rad;
    logic [31:0]   r_byp_data;
    logic          r_byp_inv;
    logic [7:0]    r_exp;
    logic [RW-1:0] r_root;
    logic          r_rem_nz;

    // -------------------------------------------------------------------
    // Operand classification (combinational on IN_DATA)
    // -------------------------------------------------------------------
    logic          w_sign;
    logic [7:0]    w_e;
    logic [22:0]   w_f;
    logic          w_special;
    logic [31:0]   w_byp_data;
    logic          w_byp_inv;
    logic [23:0]   w_m;
    logic [8:0]    w_exp_sum;
    logic [MW-1:0] w_rad;

    assign w_sign = IN_DATA[31];
    assign w_e    = IN_DATA[30:23];
    assign w_f    = IN_DATA[22:0];
    assign w_m    = {1'b1, w_f};

    always_comb begin
        w_special  = 1'b1;
        w_byp_data = QNAN;
        w_byp_inv  = 1'b0;
        if (w_e == 8'd0) begin
            // zero and denormals flush to a signed zero
            w_byp_data = {w_sign, 31'd0};
        end else if (w_e == 8'hFF && w_f != 23'd0) begin
            w_byp_inv = ~w_f[22];
        end else if (w_e == 8'hFF && !w_sign) begin
            w_byp_data = 32'h7F800000;
        end else if (w_sign) begin
            w_byp_inv = 1'b1;
        end else begin
            w_special = 1'b0;
        end
    end

    // Unbiased e = E-127 is odd exactly when E is even. Odd e gets one
    // extra left shift so the remaining exponent is even and halves cleanly.
    assign w_rad = w_e[0] ? {1'b0, w_m, {(MW-25){1'b0}}}
                          : {w_m, {(MW-24){1'b0}}};

    // (e >>> 1) + 127 equals (E + 127) >> 1 for every normal E, which
    // avoids signed arithmetic; the result always lies in 64..190.
    assign w_exp_sum = {1'b0, w_e} + 9'd127;

    // -------------------------------------------------------------------
    // Round-to-nearest-even and pack (combinational on latched root)
    // -------------------------------------------------------------------
    logic [23:0] w_mant;
    logic        w_g, w_s, w_inc;
    logic [24:0] w_sum;
    logic [31:0] w_pack;

    assign w_mant = r_root[RW-1 -: 24];
    assign w_g    = r_root[RW-25];
    assign w_s    = (|r_root[RW-26:0]) | r_rem_nz;
    assign w_inc  = w_g & (w_s | w_mant[0]);
    assign w_sum  = {1'b0, w_mant} + {24'd0, w_inc};
    // a carry out of the 24-bit significand means it rounded up to 2.0
    assign w_pack = w_sum[24] ? {1'b0, r_exp + 8'd1, 23'd0}
                              : {1'b0, r_exp, w_sum[22:0]};

    // -------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (IN_VALID) w_next = w_special ? S_BYPASS : S_ISSUE;
            S_BYPASS: w_next = S_DONE;
            S_ISSUE:  if (CORE_VAL_OUT) w_next = S_PACK;
            S_PACK:   w_next = S_DONE;
            S_DONE:   if (OUT_READY) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_out_valid   <= 1'b0;
            r_out_invalid <= 1'b0;
            r_out_data    <= 32'd0;
            r_core_val    <= 1'b0;
            r_core_rad    <= '0;
            r_byp_data    <= 32'd0;
            r_byp_inv     <= 1'b0;
            r_exp         <= 8'd0;
            r_root        <= '0;
            r_rem_nz      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (IN_VALID) begin
                        r_byp_data <= w_byp_data;
                        r_byp_inv  <= w_byp_inv;
                        r_exp      <= w_exp_sum[8:1];
                        if (!w_special) begin
                            r_core_rad <= w_rad;
                            r_core_val <= 1'b1;
                        end
                    end
                end
                S_BYPASS: begin
                    r_out_data    <= r_byp_data;
                    r_out_invalid <= r_byp_inv;
                    r_out_valid   <= 1'b1;
                end
                S_ISSUE: begin
                    // drop VAL_IN on the done edge, else the core restarts
                    if (CORE_VAL_OUT) begin
                        r_core_val <= 1'b0;
                        r_root     <= CORE_ROOT;
                        r_rem_nz   <= CORE_REM_NZ;
                    end
                end
                S_PACK: begin
                    r_out_data    <= w_pack;
                    r_out_invalid <= 1'b0;
                    r_out_valid   <= 1'b1;
                end
                S_DONE: begin
                    if (OUT_READY) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign IN_READY    = (r_state == S_IDLE) & RST_N;
    assign BUSY        = (r_state != S_IDLE);
    assign DBG_STATE   = r_state;
    assign OUT_VALID   = r_out_valid;
    assign OUT_DATA    = r_out_data;
    assign OUT_INVALID = r_out_invalid;
    assign CORE_VAL    = r_core_val;
    assign CORE_RAD    = r_core_rad;

endmodule

// File: tb/tb_sbd_sqrt_fp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sbd_sqrt_fp_ctrl
//
// Directed bench for sbd_sqrt_fp_ctrl. A behavioural square-root core
// answers CORE_VAL after a fixed latency with floor(sqrt(CORE_RAD)) and a
// remainder-nonzero flag. Expected results are hand-computed constants
// queued in exp_q and popped when the result is taken.
// ---------------------------------------------------------------------------
module tb_sbd_sqrt_fp_ctrl;

    localparam int MW       = 52;
    localparam int RW       = 26;
    localparam int CORE_LAT = 5;

    // ---------------- clock / reset ----------------
    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          IN_VALID = 1'b0;
    logic [31:0]   IN_DATA = 32'd0;
    logic          OUT_READY = 1'b0;
    logic          CORE_VAL_OUT = 1'b0;
    logic [RW-1:0] CORE_ROOT = '0;
    logic          CORE_REM_NZ = 1'b0;
    logic          IN_READY, OUT_VALID, OUT_INVALID, CORE_VAL, BUSY;
    logic [31:0]   OUT_DATA;
    logic [MW-1:0] CORE_RAD;
    logic [2:0]    DBG_STATE;

    always #5 CLK = ~CLK;

    sbd_sqrt_fp_ctrl #(.MW(MW), .RW(RW), .QNAN(32'h7FC00000)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .OUT_INVALID(OUT_INVALID),
        .CORE_VAL(CORE_VAL), .CORE_RAD(CORE_RAD),
        .CORE_VAL_OUT(CORE_VAL_OUT), .CORE_ROOT(CORE_ROOT),
        .CORE_REM_NZ(CORE_REM_NZ),
        .BUSY(BUSY), .DBG_STATE(DBG_STATE)
    );

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [32:0] exp_q[$];   // {invalid, data}
    logic        core_val_seen = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural core ----------------
    function automatic logic [RW:0] core_sqrt(input logic [MW-1:0] x);
        logic [63:0] r;
        logic [63:0] xx;
        r  = 64'd0;
        xx = {{(64-MW){1'b0}}, x};
        for (int b = RW - 1; b >= 0; b--) begin
            logic [63:0] t;
            t = r | (64'd1 << b);
            if (t * t <= xx) r = t;
        end
        return {(r * r != xx), r[RW-1:0]};
    endfunction

    logic [MW-1:0] m_rad;
    int            m_cnt = 0;
    logic          m_busy = 1'b0;

    // The core keeps running through a controller reset on purpose.
    always @(negedge CLK) begin
        logic [RW:0] res;
        CORE_VAL_OUT = 1'b0;
        if (m_busy) begin
            if (m_cnt == 0) begin
                res          = core_sqrt(m_rad);
                CORE_ROOT    = res[RW-1:0];
                CORE_REM_NZ  = res[RW];
                CORE_VAL_OUT = 1'b1;
                m_busy       = 1'b0;
            end else begin
                m_cnt--;
            end
        end else if (CORE_VAL) begin
            m_busy = 1'b1;
            m_cnt  = CORE_LAT - 1;
            m_rad  = CORE_RAD;
        end
        if (CORE_VAL) core_val_seen = 1'b1;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    // Offers one operand and returns 1 time unit after the accept edge.
    task automatic send_op(input logic [31:0] d, input logic [31:0] exp_d,
                           input logic exp_inv);
        int n;
        n = 0;
        IN_VALID = 1'b1;
        IN_DATA  = d;
        while (!IN_READY && n < 50) begin
            tick();
            n++;
        end
        check_val("accept_timeout", (n >= 50), 0);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        exp_q.push_back({exp_inv, exp_d});
    endtask

    // Takes one result, compares it with the queue head, checks the
    // channel returns to idle right after the transfer edge.
    task automatic recv_op(input string tag);
        int          n;
        logic [32:0] e;
        n = 0;
        OUT_READY = 1'b1;
        while (!OUT_VALID && n < 200) begin
            tick();
            n++;
        end
        check_val({tag, "_timeout"}, (n >= 200), 0);
        check_val({tag, "_q_empty"}, (exp_q.size() == 0), 0);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'd0;
        check_val({tag, "_data"}, OUT_DATA, e[31:0]);
        check_val({tag, "_inv"}, OUT_INVALID, e[32]);
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        check_val({tag, "_valid_clr"}, OUT_VALID, 0);
        check_val({tag, "_in_ready"}, IN_READY, 1);
    endtask

    // ---------------- special-case table ----------------
    logic [31:0] sp_in  [4] = '{32'h80000000, 32'h00000001, 32'h7F800000, 32'h7FA00000};
    logic [31:0] sp_out [4] = '{32'h80000000, 32'h00000000, 32'h7F800000, 32'h7FC00000};
    logic        sp_inv [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    // ---------------- main sequence ----------------
    initial begin
        int  n;
        logic dropped;

        // reset state
        #12;
        check_val("rst_in_ready", IN_READY, 0);
        check_val("rst_out", {OUT_VALID, OUT_INVALID, CORE_VAL, BUSY}, 0);
        check_val("rst_out_data", OUT_DATA, 0);
        check_val("rst_core_rad", CORE_RAD, 0);
        tick();
        RST_N = 1'b1;
        #1;
        check_val("rel_in_ready", IN_READY, 1);
        tick();

        // 4.0: even exponent, exact root
        send_op(32'h40800000, 32'h40000000, 1'b0);
        check_val("four_rad", CORE_RAD, 52'h4000000000000);
        check_val("four_rad_b50", CORE_RAD[50], 1);
        recv_op("four");
        tick();

        // 2.0: odd exponent; watch CORE_VAL around the done pulse
        send_op(32'h40000000, 32'h3FB504F3, 1'b0);
        check_val("two_rad", CORE_RAD, 52'h8000000000000);
        check_val("two_val_entry", CORE_VAL, 1);
        n = 0;
        dropped = 1'b0;
        tick();
        while (!CORE_VAL_OUT && n < 50) begin
            if (!CORE_VAL) dropped = 1'b1;
            tick();
            n++;
        end
        check_val("two_core_timeout", (n >= 50), 0);
        check_val("two_val_held", {dropped, CORE_VAL}, 2'b01);
        tick();
        check_val("two_val_clr", CORE_VAL, 0);
        check_val("two_pack_nv", OUT_VALID, 0);
        tick();
        check_val("two_val_low2", CORE_VAL, 0);
        check_val("two_done_v", OUT_VALID, 1);
        recv_op("two");
        tick();

        // 1.5: root needs a round-up driven by the sticky remainder
        send_op(32'h3FC00000, 32'h3F9CC471, 1'b0);
        recv_op("onefive");
        tick();

        // 9.0
        send_op(32'h41100000, 32'h40400000, 1'b0);
        recv_op("nine_a");
        tick();

        // -1.0: bypass, two edges counting the accept edge
        core_val_seen = 1'b0;
        send_op(32'hBF800000, 32'h7FC00000, 1'b1);
        check_val("neg_lat1", OUT_VALID, 0);
        @(posedge CLK);
        #1;
        check_val("neg_lat2", OUT_VALID, 1);
        check_val("neg_no_core", core_val_seen, 0);
        recv_op("neg");
        tick();

        // zero, denormal, +inf, signalling NaN
        for (int i = 0; i < 4; i++) begin
            send_op(sp_in[i], sp_out[i], sp_inv[i]);
            recv_op($sformatf("special%0d", i));
            tick();
        end

        // quiet NaN: no invalid flag
        send_op(32'hFFC00001, 32'h7FC00000, 1'b0);
        recv_op("qnan");
        tick();

        // backpressure: hold the result for 10 cycles
        send_op(32'h7F800000, 32'h7F800000, 1'b0);
        n = 0;
        while (!OUT_VALID && n < 50) begin
            tick();
            n++;
        end
        check_val("bp_timeout", (n >= 50), 0);
        for (int i = 0; i < 10; i++) begin
            check_val("bp_hold", {OUT_VALID, IN_READY, OUT_INVALID, OUT_DATA},
                      {1'b1, 1'b0, 1'b0, 32'h7F800000});
            tick();
        end
        recv_op("bp");
        tick();
        check_val("bp_single", OUT_VALID, 0);

        // reset in the middle of ISSUE
        send_op(32'h41100000, 32'h40400000, 1'b0);
        tick();
        check_val("mid_issue", {BUSY, CORE_VAL}, 2'b11);
        #2;
        RST_N = 1'b0;
        #1;
        check_val("mid_rst_async", {CORE_VAL, OUT_VALID, BUSY, IN_READY}, 0);
        exp_q.delete();
        tick();
        RST_N = 1'b1;
        n = 0;
        while (!CORE_VAL_OUT && n < 50) begin
            tick();
            n++;
        end
        check_val("mid_core_timeout", (n >= 50), 0);
        @(posedge CLK);
        #1;
        check_val("stray_val_out", {BUSY, OUT_VALID, CORE_VAL}, 0);
        tick();
        send_op(32'h41100000, 32'h40400000, 1'b0);
        recv_op("nine_b");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
